// File: rtl/scariv_predict_pkg.sv
// Shared branch-predictor types: the BTB update-queue entry and its default depth.
package scariv_predict_pkg;

  localparam int BTB_UPD_Q_DEPTH = 8;
  localparam int BTB_UPD_VADDR_W = 39;

  typedef struct packed {
    logic [BTB_UPD_VADDR_W-1:0] pc_vaddr;
    logic [BTB_UPD_VADDR_W-1:0] target_vaddr;
    logic                       is_cond;
    logic                       is_call;
    logic                       is_ret;
    logic                       is_rvc;
  } btb_upd_entry_t;

endpackage

// File: rtl/scariv_btb_upd_ring.sv
// DEPTH-entry ring with indexed multi-write, multi-enqueue tail and single-dequeue head.
module scariv_btb_upd_ring
  import scariv_predict_pkg::*;
#(
  parameter int DEPTH    = BTB_UPD_Q_DEPTH,
  parameter int IN_PORTS = 2
) (
  input  logic                                     i_clk,
  input  logic                                     i_reset_n,
  input  logic [IN_PORTS-1:0]                      wr_en_i,
  input  logic [IN_PORTS-1:0][$clog2(DEPTH)-1:0]   wr_idx_i,
  input  btb_upd_entry_t [IN_PORTS-1:0]            wr_data_i,
  input  logic [$clog2(DEPTH):0]                   enq_cnt_i,
  input  logic                                     deq_i,
  output btb_upd_entry_t                           head_o,
  output btb_upd_entry_t                           young_o,
  output logic [$clog2(DEPTH)-1:0]                 tail_ptr_o,
  output logic [$clog2(DEPTH):0]                   occ_o,
  output logic                                     full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;

  btb_upd_entry_t mem_q [DEPTH];
  logic [AW-1:0]  head_q, head_d;
  logic [AW-1:0]  tail_q, tail_d;
  logic [OW-1:0]  occ_q,  occ_d;
  logic           full_q;

  always_comb begin
    head_d = head_q + AW'(deq_i);
    tail_d = tail_q + enq_cnt_i[AW-1:0];
    occ_d  = occ_q + enq_cnt_i - OW'(deq_i);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
      full_q <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
      full_q <= (occ_d == OW'(DEPTH));
    end
  end

  // Higher lanes are written later, so they win when two lanes hit the same slot.
  always_ff @(posedge i_clk) begin
    for (int l = 0; l < IN_PORTS; l++) begin
      if (wr_en_i[l]) mem_q[wr_idx_i[l]] <= wr_data_i[l];
    end
  end

  assign head_o     = mem_q[head_q];
  assign young_o    = mem_q[tail_q - AW'(1)];
  assign tail_ptr_o = tail_q;
  assign occ_o      = occ_q;
  assign full_o     = full_q;

endmodule

// File: rtl/scariv_btb_update_queue.sv
// Filters, merges and serializes commit-stage branch resolutions into one BTB update per cycle.
module scariv_btb_update_queue
  import scariv_predict_pkg::*;
#(
  parameter int VADDR_W  = BTB_UPD_VADDR_W,
  parameter int IN_PORTS = 2,
  parameter int DEPTH    = BTB_UPD_Q_DEPTH
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic [IN_PORTS-1:0]           i_res_valid,
  input  logic [IN_PORTS*VADDR_W-1:0]   i_res_pc_vaddr,
  input  logic [IN_PORTS*VADDR_W-1:0]   i_res_target_vaddr,
  input  logic [IN_PORTS-1:0]           i_res_taken,
  input  logic [IN_PORTS-1:0]           i_res_mispredict,
  input  logic [IN_PORTS-1:0]           i_res_is_cond,
  input  logic [IN_PORTS-1:0]           i_res_is_call,
  input  logic [IN_PORTS-1:0]           i_res_is_ret,
  input  logic [IN_PORTS-1:0]           i_res_is_rvc,
  input  logic                          i_btb_ready,
  output logic                          o_btb_valid,
  output logic [VADDR_W-1:0]            o_btb_pc_vaddr,
  output logic [VADDR_W-1:0]            o_btb_target_vaddr,
  output logic                          o_btb_is_cond,
  output logic                          o_btb_is_call,
  output logic                          o_btb_is_ret,
  output logic                          o_btb_is_rvc,
  output logic                          o_full,
  output logic [15:0]                   o_drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  btb_upd_entry_t [IN_PORTS-1:0]          lane_ent;
  logic [IN_PORTS-1:0]                    qual;
  logic [IN_PORTS-1:0]                    wr_en;
  logic [IN_PORTS-1:0][AW-1:0]            wr_idx;
  btb_upd_entry_t [IN_PORTS-1:0]          wr_data;
  logic [OW-1:0]                          enq_n;
  logic [OW-1:0]                          free_n;
  logic [15:0]                            drop_n;
  logic                                   deq;

  btb_upd_entry_t                         head_ent;
  btb_upd_entry_t                         young_ent;
  logic [AW-1:0]                          tail_ptr;
  logic [OW-1:0]                          occ;
  logic                                   full;

  logic                                   young_vld;
  logic                                   young_blk;
  logic [AW-1:0]                          young_idx;
  logic [VADDR_W-1:0]                     young_pc;

  logic [15:0]                            drop_cnt_q, drop_cnt_d;

  always_comb begin
    for (int l = 0; l < IN_PORTS; l++) begin
      lane_ent[l].pc_vaddr     = i_res_pc_vaddr[l*VADDR_W +: VADDR_W];
      lane_ent[l].target_vaddr = i_res_target_vaddr[l*VADDR_W +: VADDR_W];
      lane_ent[l].is_cond      = i_res_is_cond[l];
      lane_ent[l].is_call      = i_res_is_call[l];
      lane_ent[l].is_ret       = i_res_is_ret[l];
      lane_ent[l].is_rvc       = i_res_is_rvc[l];
      qual[l] = i_res_valid[l] & (i_res_taken[l] | i_res_mispredict[l]);
    end
  end

  assign deq = (occ != '0) & i_btb_ready;

  // Lanes walk in age order; "youngest" tracks the last entry written this cycle so a
  // later lane can merge into a slot claimed by an earlier one. The head is locked
  // against merging while it is leaving, and freed slots only count next cycle.
  always_comb begin
    wr_en     = '0;
    wr_idx    = '0;
    wr_data   = '0;
    enq_n     = '0;
    drop_n    = '0;
    free_n    = OW'(DEPTH) - occ;
    young_vld = (occ != '0);
    young_blk = (occ == OW'(1)) && deq;
    young_idx = tail_ptr - AW'(1);
    young_pc  = young_ent.pc_vaddr;
    for (int l = 0; l < IN_PORTS; l++) begin
      if (qual[l]) begin
        if (young_vld && !young_blk && (lane_ent[l].pc_vaddr == young_pc)) begin
          wr_en[l]   = 1'b1;
          wr_idx[l]  = young_idx;
          wr_data[l] = lane_ent[l];
        end else if (enq_n < free_n) begin
          wr_en[l]   = 1'b1;
          wr_idx[l]  = tail_ptr + enq_n[AW-1:0];
          wr_data[l] = lane_ent[l];
          young_vld  = 1'b1;
          young_blk  = 1'b0;
          young_idx  = tail_ptr + enq_n[AW-1:0];
          young_pc   = lane_ent[l].pc_vaddr;
          enq_n      = enq_n + OW'(1);
        end else begin
          drop_n = drop_n + 16'd1;
        end
      end
    end
  end

  scariv_btb_upd_ring #(
    .DEPTH    (DEPTH),
    .IN_PORTS (IN_PORTS)
  ) u_ring (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .wr_en_i    (wr_en),
    .wr_idx_i   (wr_idx),
    .wr_data_i  (wr_data),
    .enq_cnt_i  (enq_n),
    .deq_i      (deq),
    .head_o     (head_ent),
    .young_o    (young_ent),
    .tail_ptr_o (tail_ptr),
    .occ_o      (occ),
    .full_o     (full)
  );

  assign drop_cnt_d = sat_add16(drop_cnt_q, drop_n);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) drop_cnt_q <= '0;
    else            drop_cnt_q <= drop_cnt_d;
  end

  assign o_btb_valid        = (occ != '0);
  assign o_btb_pc_vaddr     = head_ent.pc_vaddr;
  assign o_btb_target_vaddr = head_ent.target_vaddr;
  assign o_btb_is_cond      = head_ent.is_cond;
  assign o_btb_is_call      = head_ent.is_call;
  assign o_btb_is_ret       = head_ent.is_ret;
  assign o_btb_is_rvc       = head_ent.is_rvc;
  assign o_full             = full;
  assign o_drop_cnt         = drop_cnt_q;

endmodule
